// File: rtl/chan_msg_arbiter.sv
// rtl/chan_msg_arbiter.sv - round-robin arbiter for the shared inter-CPU channel message bus
// One grant per pass through IDLE; the winning payload is captured at grant and strobed one beat later.
module chan_msg_arbiter #(
    parameter int NPORT  = 4,
    parameter int MSG_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_oe,
    input  logic                      bus_busy_i,
    input  logic [NPORT-1:0]          req_i,
    input  logic [NPORT*MSG_W-1:0]    req_msg_i,
    input  logic [NPORT*ADDR_W-1:0]   req_addr_i,
    input  logic [NPORT*DATA_W-1:0]   req_data_i,
    output logic [NPORT-1:0]          ack_o,
    output logic [MSG_W-1:0]          bus_msg_o,
    output logic [ADDR_W-1:0]         bus_addr_o,
    output logic [DATA_W-1:0]         bus_data_o,
    output logic                      bus_strb_o,
    output logic                      bus_busy_o,
    output logic [2:0]                grant_id_o,
    output logic [15:0]               msg_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              r_state;
    logic [2:0]          r_ptr;
    logic [2:0]          r_grant;
    logic [NPORT-1:0]    r_ack;
    logic [MSG_W-1:0]    r_msg;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_strb;
    logic                r_busy;
    logic [15:0]         r_msg_cnt;

    logic [7:0]          w_req_ext;
    logic [2:0]          w_idx;
    logic [2:0]          w_win;
    logic                w_found;
    logic [MSG_W-1:0]    w_msg;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;

    assign w_req_ext = 8'(req_i);

    // Search upward from the port after the last winner, wrapping modulo NPORT.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = '0;
        for (int i = 1; i <= NPORT; i++) begin
            w_idx = 3'((int'(r_ptr) + i) % NPORT);
            if (!w_found && w_req_ext[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_msg  = '0;
        w_addr = '0;
        w_data = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (w_win == 3'(p)) begin
                w_msg  = req_msg_i[p*MSG_W +: MSG_W];
                w_addr = req_addr_i[p*ADDR_W +: ADDR_W];
                w_data = req_data_i[p*DATA_W +: DATA_W];
            end
        end
    end

    // Reset wins regardless of clk_oe; otherwise every register holds while clk_oe is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'(NPORT - 1);
            r_grant   <= '0;
            r_ack     <= '0;
            r_msg     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= 1'b0;
            r_busy    <= 1'b0;
            r_msg_cnt <= '0;
        end else if (clk_oe) begin
            case (r_state)
                S_IDLE: begin
                    if (w_found && !bus_busy_i) begin
                        r_msg   <= w_msg;
                        r_addr  <= w_addr;
                        r_data  <= w_data;
                        r_grant <= w_win;
                        r_ptr   <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_strb    <= 1'b1;
                    r_ack     <= NPORT'(1) << r_grant;
                    r_msg_cnt <= r_msg_cnt + 16'd1;
                    r_state   <= S_RELEASE;
                end
                S_RELEASE: begin
                    r_strb  <= 1'b0;
                    r_ack   <= '0;
                    r_msg   <= '0;
                    r_addr  <= '0;
                    r_data  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_o      = r_ack;
    assign bus_msg_o  = r_msg;
    assign bus_addr_o = r_addr;
    assign bus_data_o = r_data;
    assign bus_strb_o = r_strb;
    assign bus_busy_o = r_busy;
    assign grant_id_o = r_grant;
    assign msg_cnt_o  = r_msg_cnt;

endmodule

// File: tb/tb_chan_msg_arbiter.sv
// tb/tb_chan_msg_arbiter.sv - directed self-checking bench for chan_msg_arbiter
module tb_chan_msg_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_oe;
    logic         bus_busy_i;
    logic [3:0]   req_i;
    logic [31:0]  req_msg_i;
    logic [127:0] req_addr_i;
    logic [127:0] req_data_i;
    logic [3:0]   ack_o;
    logic [7:0]   bus_msg_o;
    logic [31:0]  bus_addr_o;
    logic [31:0]  bus_data_o;
    logic         bus_strb_o;
    logic         bus_busy_o;
    logic [2:0]   grant_id_o;
    logic [15:0]  msg_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    chan_msg_arbiter #(.NPORT(4), .MSG_W(8), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .clk_oe(clk_oe), .bus_busy_i(bus_busy_i),
        .req_i(req_i), .req_msg_i(req_msg_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .ack_o(ack_o), .bus_msg_o(bus_msg_o), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
        .bus_strb_o(bus_strb_o), .bus_busy_o(bus_busy_o), .grant_id_o(grant_id_o), .msg_cnt_o(msg_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [7:0] m, input logic [31:0] a, input logic [31:0] d);
        req_msg_i[p*8 +: 8]    = m;
        req_addr_i[p*32 +: 32] = a;
        req_data_i[p*32 +: 32] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_i = '0; bus_busy_i = 1'b0; clk_oe = 1'b1;
        req_msg_i = '0; req_addr_i = '0; req_data_i = '0;
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if ({bus_strb_o, bus_busy_o, ack_o} !== 6'b0) begin n_err++; $display("FAIL reset_ctl got %b want 000000", {bus_strb_o, bus_busy_o, ack_o}); end
        n_vec++; if ({bus_msg_o, bus_addr_o, bus_data_o} !== 72'h0) begin n_err++; $display("FAIL reset_bus got %h want 0", {bus_msg_o, bus_addr_o, bus_data_o}); end
        n_vec++; if ({grant_id_o, msg_cnt_o} !== 19'h0) begin n_err++; $display("FAIL reset_cnt got %h want 0", {grant_id_o, msg_cnt_o}); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        set_port(2, 8'h11, 32'h40, 32'hDEAD);
        req_i = 4'b0100;
        tick();
        n_vec++; if ({bus_busy_o, bus_strb_o, grant_id_o} !== {1'b1, 1'b0, 3'd2}) begin n_err++; $display("FAIL single_grant got busy=%b strb=%b gid=%0d want 1 0 2", bus_busy_o, bus_strb_o, grant_id_o); end
        tick();
        n_vec++; if ({bus_strb_o, ack_o} !== 5'b1_0100) begin n_err++; $display("FAIL single_strb got strb=%b ack=%b want 1 0100", bus_strb_o, ack_o); end
        n_vec++; if ({bus_msg_o, bus_addr_o, bus_data_o} !== {8'h11, 32'h40, 32'hDEAD}) begin n_err++; $display("FAIL single_payload got %h/%h/%h want 11/40/dead", bus_msg_o, bus_addr_o, bus_data_o); end
        req_i = '0;
        tick();
        n_vec++; if ({bus_strb_o, bus_busy_o, ack_o, bus_msg_o, bus_addr_o, bus_data_o} !== 78'h0) begin n_err++; $display("FAIL single_clear got strb=%b busy=%b ack=%b bus=%h/%h/%h want all 0", bus_strb_o, bus_busy_o, ack_o, bus_msg_o, bus_addr_o, bus_data_o); end
        n_vec++; if (msg_cnt_o !== 16'd1) begin n_err++; $display("FAIL single_cnt got %0d want 1", msg_cnt_o); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_id;
        logic [3:0] exp_ack;
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, 8'(8'hA0 + p), 32'(32'h1000 * p), 32'(32'hBEEF0 + p));
        req_i = 4'b1111;
        for (int m = 0; m < 12; m++) begin
            exp_id  = 3'(m % 4);
            exp_ack = 4'b0001 << (m % 4);
            tick();
            n_vec++; if (grant_id_o !== exp_id) begin n_err++; $display("FAIL rr_grant msg %0d got %0d want %0d", m, grant_id_o, exp_id); end
            tick();
            n_vec++; if ({bus_strb_o, ack_o, bus_msg_o} !== {1'b1, exp_ack, 8'(8'hA0 + m % 4)}) begin n_err++; $display("FAIL rr_ack msg %0d got strb=%b ack=%b msg=%h want 1 %b %h", m, bus_strb_o, ack_o, bus_msg_o, exp_ack, 8'(8'hA0 + m % 4)); end
            tick();
        end
        req_i = '0;
        n_vec++; if (msg_cnt_o !== 16'd12) begin n_err++; $display("FAIL rr_cnt got %0d want 12", msg_cnt_o); end
    endtask

    task automatic test_bus_busy();
        set_port(1, 8'h12, 32'h120, 32'h1212);
        bus_busy_i = 1'b1;
        req_i = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++; if ({bus_strb_o, bus_busy_o} !== 2'b00) begin n_err++; $display("FAIL busy_hold cycle %0d got strb=%b busy=%b want 0 0", c, bus_strb_o, bus_busy_o); end
        end
        bus_busy_i = 1'b0;
        tick();
        n_vec++; if ({bus_busy_o, grant_id_o, bus_msg_o} !== {1'b1, 3'd1, 8'h12}) begin n_err++; $display("FAIL busy_grant got busy=%b gid=%0d msg=%h want 1 1 12", bus_busy_o, grant_id_o, bus_msg_o); end
        tick();
        n_vec++; if ({bus_strb_o, ack_o} !== 5'b1_0010) begin n_err++; $display("FAIL busy_ack got strb=%b ack=%b want 1 0010", bus_strb_o, ack_o); end
        req_i = '0;
        tick();
    endtask

    task automatic test_clk_oe();
        set_port(3, 8'h33, 32'h300, 32'h3333);
        req_i = 4'b1000;
        tick();
        set_port(3, 8'h99, 32'h999, 32'h9999);
        clk_oe = 1'b0;
        tick();
        n_vec++; if ({bus_strb_o, bus_busy_o, bus_msg_o} !== {1'b0, 1'b1, 8'h33}) begin n_err++; $display("FAIL oe_frozen_grant got strb=%b busy=%b msg=%h want 0 1 33", bus_strb_o, bus_busy_o, bus_msg_o); end
        clk_oe = 1'b1;
        tick();
        n_vec++; if ({bus_strb_o, ack_o, msg_cnt_o} !== {1'b1, 4'b1000, 16'd14}) begin n_err++; $display("FAIL oe_send got strb=%b ack=%b cnt=%0d want 1 1000 14", bus_strb_o, ack_o, msg_cnt_o); end
        req_i = '0;
        clk_oe = 1'b0;
        tick();
        n_vec++; if ({bus_strb_o, ack_o, msg_cnt_o} !== {1'b1, 4'b1000, 16'd14}) begin n_err++; $display("FAIL oe_frozen_strb got strb=%b ack=%b cnt=%0d want 1 1000 14", bus_strb_o, ack_o, msg_cnt_o); end
        n_vec++; if ({bus_msg_o, bus_addr_o, bus_data_o} !== {8'h33, 32'h300, 32'h3333}) begin n_err++; $display("FAIL oe_payload got %h/%h/%h want 33/300/3333", bus_msg_o, bus_addr_o, bus_data_o); end
        clk_oe = 1'b1;
        tick();
        n_vec++; if ({bus_strb_o, ack_o, bus_busy_o} !== 6'b0) begin n_err++; $display("FAIL oe_release got strb=%b ack=%b busy=%b want 0 0000 0", bus_strb_o, ack_o, bus_busy_o); end
        tick();
        n_vec++; if ({ack_o, msg_cnt_o} !== {4'b0000, 16'd14}) begin n_err++; $display("FAIL oe_single_ack got ack=%b cnt=%0d want 0000 14", ack_o, msg_cnt_o); end
    endtask

    task automatic test_reset_in_send();
        set_port(1, 8'h21, 32'h210, 32'h2121);
        req_i = 4'b0010;
        tick();
        n_vec++; if ({bus_busy_o, grant_id_o} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL rst_pre_grant got busy=%b gid=%0d want 1 1", bus_busy_o, grant_id_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if ({bus_strb_o, bus_busy_o, ack_o, grant_id_o, msg_cnt_o, bus_msg_o} !== 33'h0) begin n_err++; $display("FAIL rst_abort got strb=%b busy=%b ack=%b gid=%0d cnt=%0d msg=%h want all 0", bus_strb_o, bus_busy_o, ack_o, grant_id_o, msg_cnt_o, bus_msg_o); end
        tick();
        n_vec++; if ({bus_strb_o, ack_o, bus_busy_o, grant_id_o} !== {1'b0, 4'b0000, 1'b1, 3'd1}) begin n_err++; $display("FAIL rst_regrant got strb=%b ack=%b busy=%b gid=%0d want 0 0000 1 1", bus_strb_o, ack_o, bus_busy_o, grant_id_o); end
        tick();
        n_vec++; if ({bus_strb_o, ack_o, bus_msg_o} !== {1'b1, 4'b0010, 8'h21}) begin n_err++; $display("FAIL rst_resend got strb=%b ack=%b msg=%h want 1 0010 21", bus_strb_o, ack_o, bus_msg_o); end
        req_i = '0;
        tick();
        n_vec++; if ({bus_busy_o, msg_cnt_o} !== {1'b0, 16'd1}) begin n_err++; $display("FAIL rst_cnt got busy=%b cnt=%0d want 0 1", bus_busy_o, msg_cnt_o); end
    endtask

    task automatic test_cnt_wrap();
        force dut.r_msg_cnt = 16'hFFFF;
        tick();
        release dut.r_msg_cnt;
        tick();
        n_vec++; if (msg_cnt_o !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload got %h want ffff", msg_cnt_o); end
        set_port(0, 8'h05, 32'h50, 32'h5555);
        req_i = 4'b0001;
        tick();
        tick();
        n_vec++; if ({bus_strb_o, ack_o, msg_cnt_o} !== {1'b1, 4'b0001, 16'h0000}) begin n_err++; $display("FAIL wrap_cnt got strb=%b ack=%b cnt=%h want 1 0001 0000", bus_strb_o, ack_o, msg_cnt_o); end
        req_i = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_bus_busy();
        test_clk_oe();
        test_reset_in_send();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
